// File: rtl/mesh_term_rx_if.sv
// rtl/mesh_term_rx_if.sv - router-side pop handshake, host-side FIFO view and statistics of mesh_term_rx
interface mesh_term_rx_if #(
  parameter int pckg_sz = 40,
  parameter int cnt_w   = 16
);
  logic               pndng_in;
  logic [pckg_sz-1:0] data_in;
  logic               pop_out;
  logic               host_pop;
  logic               host_pndng;
  logic [pckg_sz-1:0] host_data;
  logic               host_full;
  logic [cnt_w-1:0]   pkt_cnt;
  logic [cnt_w-1:0]   err_cnt;
  logic               err_flag;

  modport master (
    output pndng_in, data_in, host_pop,
    input  pop_out, host_pndng, host_data, host_full, pkt_cnt, err_cnt, err_flag
  );

  modport slave (
    input  pndng_in, data_in, host_pop,
    output pop_out, host_pndng, host_data, host_full, pkt_cnt, err_cnt, err_flag
  );
endinterface

// File: rtl/mesh_term_rx.sv
// rtl/mesh_term_rx.sv - terminal receive stage: pops router packets, checks destination, buffers in a local FIFO
// Optional RX_BCAST_EN: packets whose low pckg_sz-18 payload bits are all ones are accepted as broadcast.
module mesh_term_rx #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int id_row     = 0,
  parameter int id_col     = 1,
  parameter int cnt_w      = 16
) (
  input logic          clk,
  input logic          reset,
  mesh_term_rx_if.slave bus
);
  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH  = CW'(fifo_depth);
  localparam logic [3:0]    ROW_ID = 4'(id_row);
  localparam logic [3:0]    COL_ID = 4'(id_col);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t             state_q;
  logic [pckg_sz-1:0] cap_q;
  logic               match_q;
  logic               pop_q;
  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [cnt_w-1:0]   pkt_cnt_q, err_cnt_q;
  logic               err_flag_q;

  logic dest_hit, bcast, wr_en, rd_en;

  assign dest_hit = (cap_q[pckg_sz-9 -: 4] == ROW_ID) && (cap_q[pckg_sz-13 -: 4] == COL_ID);
`ifdef RX_BCAST_EN
  assign bcast = &cap_q[pckg_sz-19:0];
`else
  assign bcast = 1'b0;
`endif

  // Admission only happens in IDLE, so reserving on count alone keeps a SETTLE write off a full FIFO.
  assign wr_en = (state_q == SETTLE) && match_q;
  assign rd_en = bus.host_pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      match_q    <= 1'b0;
      pop_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.pndng_in && (count_q < DEPTH)) begin
            cap_q   <= bus.data_in;
            pop_q   <= 1'b1;
            state_q <= POP;
          end else begin
            pop_q <= 1'b0;
          end
        end
        POP: begin
          pop_q   <= 1'b0;
          match_q <= dest_hit || bcast;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (match_q) begin
            if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
          end else begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            err_flag_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          pop_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= cap_q;
  end

  assign bus.pop_out    = pop_q;
  assign bus.host_pndng = (count_q != '0);
  assign bus.host_full  = (count_q == DEPTH);
  assign bus.host_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.pkt_cnt    = pkt_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_flag   = err_flag_q;
endmodule

// File: tb/tb_mesh_term_rx.sv
// tb/tb_mesh_term_rx.sv - scoreboard bench for mesh_term_rx with a queue-based router model
module tb_mesh_term_rx;
  localparam int PW   = 40;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mesh_term_rx_if #(.pckg_sz(PW), .cnt_w(CNTW)) bus ();

  mesh_term_rx #(
    .pckg_sz(PW), .fifo_depth(4), .id_row(0), .id_col(1), .cnt_w(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] rtr_q[$];
  logic [PW-1:0] exp_q[$];
  int exp_pkt = 0, exp_err = 0, pushed = 0, pops = 0, consumed = 0;
  bit prev_pop = 0, last_pop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int row, input int col, input logic [22:0] pl);
    logic [7:0] nj;
    logic       md;
    nj = 8'($urandom);
    md = 1'($urandom);
    return {nj, 4'(row), 4'(col), md, pl};
  endfunction

  function automatic bit accepts(input logic [PW-1:0] p);
    bit hit;
    hit = (p[31:28] == 4'd0) && (p[27:24] == 4'd1);
`ifdef RX_BCAST_EN
    if (&p[21:0]) hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic send(input logic [PW-1:0] p);
    rtr_q.push_back(p);
    pushed++;
    if (accepts(p)) begin
      exp_q.push_back(p);
      exp_pkt++;
    end else begin
      exp_err++;
    end
  endtask

  // Router output FIFO: pops on the edge that sees pop_out high.
  initial begin
    bus.pndng_in = 1'b0;
    bus.data_in  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_pop && rtr_q.size() > 0) void'(rtr_q.pop_front());
      prev_pop     = bus.pop_out;
      bus.pndng_in = (rtr_q.size() != 0);
      bus.data_in  = (rtr_q.size() != 0) ? rtr_q[0] : '0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pop_out) begin
        pops++;
        chk("pop_one_cycle", {63'd0, last_pop}, 64'd0);
      end
      last_pop = bus.pop_out;
      if (bus.host_pop && bus.host_pndng) begin
        consumed++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL host_word: got %0h expected no word", bus.host_data);
        end else begin
          chk("host_data_order", {24'd0, bus.host_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end else begin
      last_pop = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.pop_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL pop_timeout: got no pop_out expected pop_out within 50 cycles");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.host_pop = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (rtr_q.size() == 0 && exp_q.size() == 0 && !bus.host_pndng) begin
        done = 1'b1;
        break;
      end
    end
    tick(4);
    bus.host_pop = 1'b0;
    tick();
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_pkt_cnt"}, 64'(bus.pkt_cnt), 64'(exp_pkt));
    chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'(exp_err));
    chk({tag, "_err_flag"}, {63'd0, bus.err_flag}, {63'd0, exp_err != 0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    bit ok;
    int base, cbase, r;

    bus.host_pop = 1'b0;
    reset = 1'b1;
    tick(3);
    chk("rst_pop_out", {63'd0, bus.pop_out}, 64'd0);
    chk("rst_host_pndng", {63'd0, bus.host_pndng}, 64'd0);
    chk("rst_host_full", {63'd0, bus.host_full}, 64'd0);
    chk("rst_host_data", 64'(bus.host_data), 64'd0);
    check_counters("rst");
    reset = 1'b0;
    tick();

    // Single matching packet: latency and content.
    p = mk(0, 1, 23'h00ABCD);
    send(p);
    wait_pop(ok);
    if (ok) begin
      tick();
      chk("t1_pndng_early", {63'd0, bus.host_pndng}, 64'd0);
      tick();
      chk("t1_pndng", {63'd0, bus.host_pndng}, 64'd1);
      chk("t1_data", 64'(bus.host_data), 64'(p));
      chk("t1_pkt_cnt", 64'(bus.pkt_cnt), 64'd1);
    end
    drain();
    check_counters("t1");

    // Misrouted packet.
    send(mk(2, 3, 23'($urandom)));
    drain();
    chk("t2_fifo_empty", {63'd0, bus.host_pndng}, 64'd0);
    check_counters("t2");

    // Backpressure: only four fit.
    base = pops;
    repeat (6) send(mk(0, 1, 23'($urandom)));
    tick(40);
    chk("t3_pops4", 64'(pops - base), 64'd4);
    chk("t3_full", {63'd0, bus.host_full}, 64'd1);
    chk("t3_pop_idle", {63'd0, bus.pop_out}, 64'd0);
    chk("t3_router_left", 64'(rtr_q.size()), 64'd2);
    bus.host_pop = 1'b1;
    tick();
    bus.host_pop = 1'b0;
    tick(10);
    chk("t3_pops5", 64'(pops - base), 64'd5);
    chk("t3_refull", {63'd0, bus.host_full}, 64'd1);
    drain();
    check_counters("t3");

    // Host pop coincident with each SETTLE write, FIFO holding two.
    send(mk(0, 1, 23'($urandom)));
    send(mk(0, 1, 23'($urandom)));
    tick(12);
    for (int i = 0; i < 8; i++) begin
      send(mk(0, 1, 23'($urandom)));
      wait_pop(ok);
      if (!ok) break;
      tick();
      bus.host_pop = 1'b1;
      tick();
      bus.host_pop = 1'b0;
      chk("t4_pndng", {63'd0, bus.host_pndng}, 64'd1);
      chk("t4_not_full", {63'd0, bus.host_full}, 64'd0);
    end
    tick(4);
    cbase = consumed;
    bus.host_pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.host_pndng) break;
    end
    bus.host_pop = 1'b0;
    chk("t4_left", 64'(consumed - cbase), 64'd2);
    drain();
    check_counters("t4");

    // Reset while in POP.
    send(mk(0, 1, 23'($urandom)));
    wait_pop(ok);
    reset = 1'b1;
    tick();
    chk("t5_pop_out", {63'd0, bus.pop_out}, 64'd0);
    chk("t5_pndng", {63'd0, bus.host_pndng}, 64'd0);
    exp_q.delete();
    rtr_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    check_counters("t5_rst");
    reset = 1'b0;
    tick();
    send(mk(0, 1, 23'($urandom)));
    drain();
    check_counters("t5_after");

    // Broadcast-pattern packet to a foreign destination.
    send(mk(3, 2, {1'b0, 22'h3FFFFF}));
    drain();
    check_counters("t6");

    // Randomized traffic with random host consumption.
    base = pops;
    r = pushed;
    for (int i = 0; i < 300; i++) begin
      bus.host_pop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: send(mk(0, 1, 23'($urandom)));
          5, 6:          send(mk($urandom_range(0, 15), $urandom_range(0, 15), 23'($urandom)));
          default:       send(mk($urandom_range(0, 15), $urandom_range(0, 15), {1'($urandom), 22'h3FFFFF}));
        endcase
      end
      tick();
    end
    drain();
    check_counters("t7");
    chk("t7_pops", 64'(pops - base), 64'(pushed - r));
    chk("t7_empty", {63'd0, bus.host_pndng}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
